// File: rtl/reg_access_arbiter.sv
// ---------------------------------------------------------------------------
// reg_access_arbiter
//
// Single-port access controller for a 2^AW x DW configuration register array
// shared by two requesters: the host register port (cfg_*) and the
// deserialised two-wire port (twp_*). Each grant runs exactly one RAM access
// through IDLE -> ACC -> DONE -> IDLE.
//
// Handshake (both requesters): req is a level held with cmd/addr/wdata until
// the one-cycle completion pulse (cfg_rdy / twp_ack). The requester drops req
// in the cycle after the pulse; a req still high then is a new request. The
// winner's cmd/addr/wdata are captured at grant, so later changes are ignored.
//
// Compile-time option: ARB_ROUND_ROBIN_EN
//   defined   - round-robin between cfg and twp (pointer starts favouring cfg)
//   undefined - fixed priority, cfg over twp
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   cfg_req/cmd/addr/wdata     host request (cmd 1 = write, 0 = read)
//   cfg_rdy, cfg_rdata         host completion pulse, read data
//   twp_req/cmd/addr/wdata     two-wire request
//   twp_ack, twp_rdata         two-wire completion pulse, read data
//   twp_drop                   with twp_ack: twp write discarded by collision
//   ram_en/we/addr/wdata       RAM access strobe, write enable, address, data
//   ram_rdata                  RAM read data, one cycle after ram_en
//   drop_cnt                   saturating count of discarded twp writes
// ---------------------------------------------------------------------------
module reg_access_arbiter #(
    parameter int AW    = 8,
    parameter int DW    = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_req,
    input  logic             cfg_cmd,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [DW-1:0]    cfg_wdata,
    output logic             cfg_rdy,
    output logic [DW-1:0]    cfg_rdata,
    input  logic             twp_req,
    input  logic             twp_cmd,
    input  logic [AW-1:0]    twp_addr,
    input  logic [DW-1:0]    twp_wdata,
    output logic             twp_ack,
    output logic [DW-1:0]    twp_rdata,
    output logic             twp_drop,
    output logic             ram_en,
    output logic             ram_we,
    output logic [AW-1:0]    ram_addr,
    output logic [DW-1:0]    ram_wdata,
    input  logic [DW-1:0]    ram_rdata,
    output logic [CNT_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic             cmd_q;      // captured command of the winner
    logic             gnt_twp_q;  // 1 = twp owns the current access
    logic             coll_q;     // current access is a same-address write collision
    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    wdata_q;
    logic [DW-1:0]    cfg_rdata_q;
    logic [DW-1:0]    twp_rdata_q;
    logic [CNT_W-1:0] drop_cnt_q;

    logic any_req;
    logic collision;
    logic pick_twp;
    logic done;

    assign any_req   = cfg_req || twp_req;
    // Only two writes to the same address collide; cfg's write is the one kept.
    assign collision = cfg_req && twp_req && cfg_cmd && twp_cmd && (cfg_addr == twp_addr);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_twp_q;  // 1 = twp was granted last, so cfg wins the next tie

    // Collisions always go to cfg, whatever the pointer says.
    assign pick_twp = twp_req && (!cfg_req || (!collision && !last_twp_q));

    always_ff @(posedge clk) begin
        if (reset) begin
            last_twp_q <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last_twp_q <= pick_twp;
        end
    end
`else
    assign pick_twp = twp_req && !cfg_req;
`endif

    // Strobes are gated by reset so a reset landing in ACC or DONE suppresses
    // the RAM write and the completion pulse in that same cycle.
    assign ram_en    = (state == ACC) && !reset;
    assign ram_we    = ram_en && cmd_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;

    assign done      = (state == DONE) && !reset;
    assign cfg_rdy   = done && (!gnt_twp_q || coll_q);
    assign twp_ack   = done && (gnt_twp_q || coll_q);
    assign twp_drop  = done && coll_q;
    assign drop_cnt  = drop_cnt_q;

    // RAM data only arrives in DONE, so the completing read is passed through
    // during its pulse; the holding register keeps it visible afterwards.
    assign cfg_rdata = (cfg_rdy && !cmd_q) ? ram_rdata : cfg_rdata_q;
    assign twp_rdata = (twp_ack && !cmd_q) ? ram_rdata : twp_rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cmd_q       <= 1'b0;
            gnt_twp_q   <= 1'b0;
            coll_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cfg_rdata_q <= '0;
            twp_rdata_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= ACC;
                        gnt_twp_q <= pick_twp;
                        coll_q    <= collision;
                        cmd_q     <= pick_twp ? twp_cmd   : cfg_cmd;
                        addr_q    <= pick_twp ? twp_addr  : cfg_addr;
                        wdata_q   <= pick_twp ? twp_wdata : cfg_wdata;
                    end
                end
                ACC: begin
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                    if (!cmd_q) begin
                        if (gnt_twp_q) begin
                            twp_rdata_q <= ram_rdata;
                        end else begin
                            cfg_rdata_q <= ram_rdata;
                        end
                    end
                    if (coll_q && (drop_cnt_q != '1)) begin
                        drop_cnt_q <= drop_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_access_arbiter
//
// Bench for reg_access_arbiter (AW=8, DW=16, CNT_W=8) with a behavioural
// register RAM. A transaction-level reference model predicts, per request
// pair, the completion cycle of each requester, the read data, the drop flag,
// the number of RAM writes and the drop counter.
// ---------------------------------------------------------------------------
module tb_reg_access_arbiter;

    logic        clk;
    logic        reset;
    logic        cfg_req, cfg_cmd, twp_req, twp_cmd;
    logic [7:0]  cfg_addr, twp_addr;
    logic [15:0] cfg_wdata, twp_wdata;
    logic        cfg_rdy, twp_ack, twp_drop;
    logic [15:0] cfg_rdata, twp_rdata;
    logic        ram_en, ram_we;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata, ram_rdata;
    logic [7:0]  drop_cnt;

    reg_access_arbiter #(.AW(8), .DW(16), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .cfg_req(cfg_req), .cfg_cmd(cfg_cmd), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_rdy(cfg_rdy), .cfg_rdata(cfg_rdata),
        .twp_req(twp_req), .twp_cmd(twp_cmd), .twp_addr(twp_addr), .twp_wdata(twp_wdata),
        .twp_ack(twp_ack), .twp_rdata(twp_rdata), .twp_drop(twp_drop),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .drop_cnt(drop_cnt)
    );

    // ---------------- clock / reset / RAM ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] ram [256] = '{default: 16'h0000};
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            ram_rdata <= ram[ram_addr];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // ---------------- types ----------------
    typedef struct {
        bit          en;
        bit          cmd;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } req_t;

    typedef struct {
        int          c_cyc;   // cycle of cfg_rdy relative to request cycle, -1 none
        int          t_cyc;   // cycle of twp_ack, -1 none
        int          we_cnt;  // RAM writes seen
        int          we_cyc;  // cycle of first RAM write, -1 none
        logic [15:0] c_rd;    // cfg_rdata during its pulse
        logic [15:0] t_rd;    // twp_rdata during its pulse
        bit          t_drp;   // twp_drop during twp_ack
        int          extra;   // pulses nobody asked for
    } res_t;

    typedef struct {
        req_t c;
        req_t t;
        res_t e;
        int   drops;
    } vec_t;

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic req_t mk_req(bit en, bit cmd, logic [7:0] addr, logic [15:0] wd);
        req_t r;
        r.en = en; r.cmd = cmd; r.addr = addr; r.wdata = wd;
        return r;
    endfunction

    function automatic res_t mk_res(int c_cyc, logic [15:0] c_rd, int t_cyc, logic [15:0] t_rd,
                                    bit t_drp, int we_cnt, int we_cyc);
        res_t r;
        r.c_cyc = c_cyc; r.c_rd = c_rd; r.t_cyc = t_cyc; r.t_rd = t_rd;
        r.t_drp = t_drp; r.we_cnt = we_cnt; r.we_cyc = we_cyc; r.extra = 0;
        return r;
    endfunction

    // ---------------- reference model ----------------
    logic [15:0] m_mem [256] = '{default: 16'h0000};
    int          m_drops;
    bit          m_last_twp;
    logic [15:0] m_last_c_rd, m_last_t_rd;

    task automatic model_reset();
        m_drops     = 0;
        m_last_twp  = 1'b1;
        m_last_c_rd = 16'h0;
        m_last_t_rd = 16'h0;
    endtask

    task automatic serve(input req_t r, input bit is_twp, input int done_cyc, inout res_t e);
        m_last_twp = is_twp;
        if (r.cmd) begin
            m_mem[r.addr] = r.wdata;
            e.we_cnt++;
            if (e.we_cyc < 0) e.we_cyc = done_cyc - 1;
        end else if (is_twp) begin
            m_last_t_rd = m_mem[r.addr];
        end else begin
            m_last_c_rd = m_mem[r.addr];
        end
        if (is_twp) begin
            e.t_cyc = done_cyc; e.t_rd = m_last_t_rd;
        end else begin
            e.c_cyc = done_cyc; e.c_rd = m_last_c_rd;
        end
    endtask

    // Whole-transaction prediction: each grant completes 2 cycles after it
    // starts; a second pending requester starts 3 cycles after the first.
    task automatic model_pair(input req_t c, input req_t t, output res_t e);
        bit coll;
        bit twp_first;
        e = mk_res(-1, 16'h0, -1, 16'h0, 1'b0, 0, -1);
        coll = c.en && t.en && c.cmd && t.cmd && (c.addr == t.addr);
        if (coll) begin
            m_mem[c.addr] = c.wdata;
            e.c_cyc = 2; e.t_cyc = 2; e.t_drp = 1'b1;
            e.we_cnt = 1; e.we_cyc = 1;
            e.c_rd = m_last_c_rd; e.t_rd = m_last_t_rd;
            if (m_drops < 255) m_drops++;
            m_last_twp = 1'b0;
        end else begin
            twp_first = t.en && (!c.en || (RR && !m_last_twp));
            if (twp_first) begin
                serve(t, 1'b1, 2, e);
                if (c.en) serve(c, 1'b0, 5, e);
            end else if (c.en) begin
                serve(c, 1'b0, 2, e);
                if (t.en) serve(t, 1'b1, 5, e);
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic reset_dut();
        @(posedge clk); #1;
        reset = 1'b1; cfg_req = 1'b0; twp_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    // Raises both requests in the same cycle (cycle 0), drops each one the
    // cycle after its completion pulse, and records what the DUT did.
    task automatic run_pair(input req_t c, input req_t t, output res_t a);
        bit c_live, t_live;
        a = mk_res(-1, 16'h0, -1, 16'h0, 1'b0, 0, -1);
        @(posedge clk); #1;
        cfg_req = c.en; cfg_cmd = c.cmd; cfg_addr = c.addr; cfg_wdata = c.wdata;
        twp_req = t.en; twp_cmd = t.cmd; twp_addr = t.addr; twp_wdata = t.wdata;
        c_live = c.en; t_live = t.en;
        for (int cyc = 0; cyc < 10 && (c_live || t_live); cyc++) begin
            @(negedge clk);
            if (ram_en && ram_we) begin
                a.we_cnt++;
                if (a.we_cyc < 0) a.we_cyc = cyc;
            end
            if (cfg_rdy) begin
                if (!c_live) a.extra++;
                else begin a.c_cyc = cyc; a.c_rd = cfg_rdata; c_live = 1'b0; end
            end
            if (twp_ack) begin
                if (!t_live) a.extra++;
                else begin a.t_cyc = cyc; a.t_rd = twp_rdata; a.t_drp = twp_drop; t_live = 1'b0; end
            end
            if (twp_drop && !twp_ack) a.extra++;
            @(posedge clk); #1;
            if (!c_live) cfg_req = 1'b0;
            if (!t_live) twp_req = 1'b0;
        end
    endtask

    task automatic check_res(input string tag, input res_t a, input res_t e, input bit c_en, input bit t_en);
        check($sformatf("%s cfg_cycle", tag), 32'(a.c_cyc), 32'(e.c_cyc));
        check($sformatf("%s twp_cycle", tag), 32'(a.t_cyc), 32'(e.t_cyc));
        if (c_en) check($sformatf("%s cfg_rdata", tag), 32'(a.c_rd), 32'(e.c_rd));
        if (t_en) begin
            check($sformatf("%s twp_rdata", tag), 32'(a.t_rd), 32'(e.t_rd));
            check($sformatf("%s twp_drop", tag), 32'(a.t_drp), 32'(e.t_drp));
        end
        check($sformatf("%s ram_writes", tag), 32'(a.we_cnt), 32'(e.we_cnt));
        check($sformatf("%s ram_we_cycle", tag), 32'(a.we_cyc), 32'(e.we_cyc));
        check($sformatf("%s stray_pulses", tag), 32'(a.extra), 32'd0);
    endtask

    // Model-checked transaction, including RAM contents and rdata hold.
    task automatic do_pair(input string tag, input req_t c, input req_t t);
        res_t a, e;
        model_pair(c, t, e);
        run_pair(c, t, a);
        check_res(tag, a, e, c.en, t.en);
        check($sformatf("%s drop_cnt", tag), 32'(drop_cnt), 32'(m_drops));
        if (c.en) check($sformatf("%s ram_cfg_addr", tag), 32'(ram[c.addr]), 32'(m_mem[c.addr]));
        if (t.en) check($sformatf("%s ram_twp_addr", tag), 32'(ram[t.addr]), 32'(m_mem[t.addr]));
        @(negedge clk);
        check($sformatf("%s cfg_rdata_hold", tag), 32'(cfg_rdata), 32'(m_last_c_rd));
        check($sformatf("%s twp_rdata_hold", tag), 32'(twp_rdata), 32'(m_last_t_rd));
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs [7];

    initial begin
        res_t a, e_unused;
        int   stray;
        req_t c, t;
        int   sel;
        logic [7:0] ad;

        // Directed vectors, starting from reset with an all-zero RAM.
        vecs[0] = '{c: mk_req(1, 1, 8'h12, 16'hA5A5), t: mk_req(0, 0, 8'h00, 16'h0000),
                    e: mk_res(2, 16'h0000, -1, 16'h0000, 0, 1, 1), drops: 0};
        vecs[1] = '{c: mk_req(1, 0, 8'h12, 16'h0000), t: mk_req(0, 0, 8'h00, 16'h0000),
                    e: mk_res(2, 16'hA5A5, -1, 16'h0000, 0, 0, -1), drops: 0};
        vecs[2] = '{c: mk_req(0, 0, 8'h00, 16'h0000), t: mk_req(1, 1, 8'h40, 16'h1234),
                    e: mk_res(-1, 16'h0000, 2, 16'h0000, 0, 1, 1), drops: 0};
        vecs[3] = '{c: mk_req(0, 0, 8'h00, 16'h0000), t: mk_req(1, 0, 8'h40, 16'h0000),
                    e: mk_res(-1, 16'h0000, 2, 16'h1234, 0, 0, -1), drops: 0};
        vecs[4] = '{c: mk_req(1, 1, 8'h05, 16'hFFFF), t: mk_req(1, 1, 8'h05, 16'h0001),
                    e: mk_res(2, 16'hA5A5, 2, 16'h1234, 1, 1, 1), drops: 1};
        vecs[5] = '{c: mk_req(1, 0, 8'h05, 16'h0000), t: mk_req(0, 0, 8'h00, 16'h0000),
                    e: mk_res(2, 16'hFFFF, -1, 16'h0000, 0, 0, -1), drops: 1};
`ifdef ARB_ROUND_ROBIN_EN
        vecs[6] = '{c: mk_req(1, 0, 8'h12, 16'h0000), t: mk_req(1, 0, 8'h40, 16'h0000),
                    e: mk_res(5, 16'hA5A5, 2, 16'h1234, 0, 0, -1), drops: 1};
`else
        vecs[6] = '{c: mk_req(1, 0, 8'h12, 16'h0000), t: mk_req(1, 0, 8'h40, 16'h0000),
                    e: mk_res(2, 16'hA5A5, 5, 16'h1234, 0, 0, -1), drops: 1};
`endif

        reset = 1'b1;
        cfg_req = 1'b0; cfg_cmd = 1'b0; cfg_addr = 8'h0; cfg_wdata = 16'h0;
        twp_req = 1'b0; twp_cmd = 1'b0; twp_addr = 8'h0; twp_wdata = 16'h0;
        model_reset();

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset cfg_rdy", 32'(cfg_rdy), 32'd0);
        check("reset twp_ack", 32'(twp_ack), 32'd0);
        check("reset twp_drop", 32'(twp_drop), 32'd0);
        check("reset ram_en", 32'(ram_en), 32'd0);
        check("reset ram_we", 32'(ram_we), 32'd0);
        check("reset ram_addr", 32'(ram_addr), 32'd0);
        check("reset ram_wdata", 32'(ram_wdata), 32'd0);
        check("reset cfg_rdata", 32'(cfg_rdata), 32'd0);
        check("reset twp_rdata", 32'(twp_rdata), 32'd0);
        check("reset drop_cnt", 32'(drop_cnt), 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < 7; i++) begin
            model_pair(vecs[i].c, vecs[i].t, e_unused);
            run_pair(vecs[i].c, vecs[i].t, a);
            check_res($sformatf("vec%0d", i), a, vecs[i].e, vecs[i].c.en, vecs[i].t.en);
            check($sformatf("vec%0d drop_cnt", i), 32'(drop_cnt), 32'(vecs[i].drops));
        end
        check("vec4 ram_05", 32'(ram[8'h05]), 32'h0000FFFF);

        // Reset during ACC of a cfg write: no RAM write, no completion.
        @(posedge clk); #1;
        cfg_req = 1'b1; cfg_cmd = 1'b1; cfg_addr = 8'h07; cfg_wdata = 16'hBEEF;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("abort ram_en", 32'(ram_en), 32'd0);
        check("abort ram_we", 32'(ram_we), 32'd0);
        check("abort cfg_rdy", 32'(cfg_rdy), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; cfg_req = 1'b0;
        model_reset();
        stray = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (cfg_rdy || twp_ack || ram_en) stray++;
        end
        check("abort stray_activity", 32'(stray), 32'd0);
        check("abort drop_cnt", 32'(drop_cnt), 32'd0);
        check("abort ram_07", 32'(ram[8'h07]), 32'h0);
        do_pair("abort_reread", mk_req(1, 0, 8'h07, 16'h0), mk_req(0, 0, 8'h00, 16'h0));

        // Randomized traffic on a small address window to provoke collisions.
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(1, 3);
            c = mk_req(sel[0], 1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)), 16'($urandom));
            t = mk_req(sel[1], 1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)), 16'($urandom));
            do_pair($sformatf("rnd%0d", i), c, t);
        end

        // Drop counter saturation: 2^CNT_W + 3 collisions.
        reset_dut();
        for (int k = 1; k <= 259; k++) begin
            ad = 8'($urandom_range(0, 255));
            do_pair($sformatf("sat%0d", k), mk_req(1, 1, ad, 16'($urandom)), mk_req(1, 1, ad, 16'($urandom)));
            if (k == 254) check("sat drop_cnt_254", 32'(drop_cnt), 32'h000000FE);
            if (k == 255) check("sat drop_cnt_255", 32'(drop_cnt), 32'h000000FF);
            if (k == 259) check("sat drop_cnt_259", 32'(drop_cnt), 32'h000000FF);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
